// File: rtl/sfx_pkg.sv
// Shared constants for the sound-effect scheduler: effect ids, effect
// lengths, FSM encoding and the note divider table (100 MHz clock,
// full-period counts, 0 = rest).
package sfx_pkg;

  localparam logic [1:0] SFX_NONE  = 2'd0;
  localparam logic [1:0] SFX_JUMP  = 2'd1;
  localparam logic [1:0] SFX_SCORE = 2'd2;
  localparam logic [1:0] SFX_OVER  = 2'd3;

  localparam int LEN_JUMP  = 4;
  localparam int LEN_SCORE = 8;
  localparam int LEN_OVER  = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Index of the final beat of an effect.
  function automatic logic [3:0] effect_last(input logic [1:0] id);
    case (id)
      SFX_JUMP:  effect_last = 4'(LEN_JUMP - 1);
      SFX_SCORE: effect_last = 4'(LEN_SCORE - 1);
      SFX_OVER:  effect_last = 4'(LEN_OVER - 1);
      default:   effect_last = 4'd0;
    endcase
  endfunction

  // Raw divider for (effect, beat); 0 marks a rest.
  function automatic logic [21:0] note_lookup(input logic [1:0] id, input logic [3:0] beat);
    note_lookup = 22'd0;
    case (id)
      SFX_JUMP: begin
        case (beat[1:0])
          2'd0: note_lookup = 22'd191113;   // C5
          2'd1: note_lookup = 22'd151686;   // E5
          2'd2: note_lookup = 22'd127552;   // G5
          default: note_lookup = 22'd95556; // C6
        endcase
      end
      SFX_SCORE: begin
        case (beat[2:0])
          3'd0: note_lookup = 22'd127552;
          3'd1: note_lookup = 22'd0;
          3'd2: note_lookup = 22'd127552;
          3'd3: note_lookup = 22'd95556;
          3'd4: note_lookup = 22'd75843;
          3'd5: note_lookup = 22'd0;
          3'd6: note_lookup = 22'd95556;
          default: note_lookup = 22'd63776;
        endcase
      end
      SFX_OVER: begin
        case (beat)
          4'd0:  note_lookup = 22'd127552;
          4'd1:  note_lookup = 22'd151686;
          4'd2:  note_lookup = 22'd191113;
          4'd3:  note_lookup = 22'd0;
          4'd4:  note_lookup = 22'd255102;
          4'd5:  note_lookup = 22'd303370;
          4'd6:  note_lookup = 22'd382226;
          4'd7:  note_lookup = 22'd0;
          4'd8:  note_lookup = 22'd454545;
          4'd9:  note_lookup = 22'd0;
          4'd10: note_lookup = 22'd510204;
          4'd11: note_lookup = 22'd510204;
          4'd12: note_lookup = 22'd0;
          default: note_lookup = 22'd764526;
        endcase
      end
      default: note_lookup = 22'd0;
    endcase
  endfunction

endpackage

// File: rtl/sfx_req_latch.sv
// Rising-edge detector with a sticky pending bit for one effect requester.
module sfx_req_latch
  import sfx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic active_match, // this id is currently playing: edges are dropped
  input  logic grant,        // this id is being granted: pending clears
  output logic pending
);

  logic prev_reg;
  logic pending_reg;
  logic req_edge;

  assign req_edge = req & ~prev_reg;
  assign pending  = pending_reg;

  // Track request history and hold pending until granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg    <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      prev_reg <= req;
      if (grant)
        pending_reg <= 1'b0;
      else if (req_edge && !active_match)
        pending_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/sfx_scheduler.sv
// Fixed-priority, preemptive sound-effect sequencer. Plays one effect at a
// time on beat ticks, inserts a silent gap between effects and drives the
// registered note divider for the note generator.
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int          GAP_BEATS  = 2,
  parameter logic [21:0] SILENT_DIV = 22'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        beat_tick,
  input  logic        req_jump,
  input  logic        req_score,
  input  logic        req_over,
  input  logic        mute,
  output logic [21:0] note_div,
  output logic [1:0]  active_id,
  output logic [3:0]  beat_idx,
  output logic        busy,
  output logic        done
);

  localparam int GAP_W = (GAP_BEATS > 1) ? $clog2(GAP_BEATS + 1) : 1;

  logic [1:0]       state_reg, state_next;
  logic [1:0]       active_id_reg, active_id_next;
  logic [3:0]       beat_reg, beat_next;
  logic [GAP_W-1:0] gap_reg, gap_next;
  logic             done_reg, done_next;
  logic [21:0]      note_div_reg, note_div_next;

  logic [3:1] req_vec;
  logic [3:1] pending_vec;
  logic [3:1] grant_vec;
  logic [1:0] grant_id;
  logic [1:0] hi_id;
  logic [21:0] raw_div;

  assign req_vec = {req_over, req_score, req_jump};

  generate
    for (genvar gi = 1; gi <= 3; gi++) begin : g_req
      assign grant_vec[gi] = (grant_id == 2'(gi));
      sfx_req_latch u_latch (
        .clk          (clk),
        .rst          (rst),
        .req          (req_vec[gi]),
        .active_match ((state_reg == ST_PLAY) && (active_id_reg == 2'(gi))),
        .grant        (grant_vec[gi]),
        .pending      (pending_vec[gi])
      );
    end
  endgenerate

  // Highest-priority pending id (over > score > jump).
  always_comb begin
    hi_id = SFX_NONE;
    if (pending_vec[3])      hi_id = SFX_OVER;
    else if (pending_vec[2]) hi_id = SFX_SCORE;
    else if (pending_vec[1]) hi_id = SFX_JUMP;
  end

  // Sequencing: grant, preempt, beat advance, completion and gap countdown.
  always_comb begin
    state_next     = state_reg;
    active_id_next = active_id_reg;
    beat_next      = beat_reg;
    gap_next       = gap_reg;
    done_next      = 1'b0;
    grant_id       = SFX_NONE;
    case (state_reg)
      ST_IDLE: begin
        if (hi_id != SFX_NONE) begin
          grant_id       = hi_id;
          state_next     = ST_PLAY;
          active_id_next = hi_id;
          beat_next      = 4'd0;
        end
      end
      ST_PLAY: begin
        if (hi_id > active_id_reg) begin
          // Preemption wins over a coincident tick; old effect is abandoned.
          grant_id       = hi_id;
          active_id_next = hi_id;
          beat_next      = 4'd0;
        end else if (beat_tick) begin
          if (beat_reg == effect_last(active_id_reg)) begin
            done_next      = 1'b1;
            active_id_next = SFX_NONE;
            beat_next      = 4'd0;
            if (GAP_BEATS == 0) begin
              state_next = ST_IDLE;
            end else begin
              state_next = ST_GAP;
              gap_next   = GAP_W'(GAP_BEATS);
            end
          end else begin
            beat_next = beat_reg + 4'd1;
          end
        end
      end
      ST_GAP: begin
        if (beat_tick) begin
          if (gap_reg <= GAP_W'(1)) state_next = ST_IDLE;
          else                      gap_next   = gap_reg - GAP_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Divider for the current registered effect/beat; silent unless playing.
  assign raw_div = note_lookup(active_id_reg, beat_reg);
  always_comb begin
    note_div_next = SILENT_DIV;
    if (state_reg == ST_PLAY && !mute && raw_div != 22'd0)
      note_div_next = raw_div;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      active_id_reg <= SFX_NONE;
      beat_reg      <= 4'd0;
      gap_reg       <= '0;
      done_reg      <= 1'b0;
      note_div_reg  <= SILENT_DIV;
    end else begin
      state_reg     <= state_next;
      active_id_reg <= active_id_next;
      beat_reg      <= beat_next;
      gap_reg       <= gap_next;
      done_reg      <= done_next;
      note_div_reg  <= note_div_next;
    end
  end

  assign note_div  = note_div_reg;
  assign active_id = active_id_reg;
  assign beat_idx  = beat_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = done_reg;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Self-checking bench for sfx_scheduler: a vector table for the basic jump
// effect, directed corner-case sequences and randomized traffic, all checked
// every cycle against a behavioural model of the scheduling rules.
module tb_sfx_scheduler;

  localparam int GAP = 2;
  localparam int SIL = 1;

  logic clk = 1'b0;
  logic rst, beat_tick, req_jump, req_score, req_over, mute;
  logic [21:0] note_div;
  logic [1:0]  active_id;
  logic [3:0]  beat_idx;
  logic        busy, done;

  sfx_scheduler #(.GAP_BEATS(GAP), .SILENT_DIV(22'd1)) dut (
    .clk(clk), .rst(rst), .beat_tick(beat_tick),
    .req_jump(req_jump), .req_score(req_score), .req_over(req_over),
    .mute(mute), .note_div(note_div), .active_id(active_id),
    .beat_idx(beat_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Musical content of each effect (0 = rest).
  int tbl_j [0:3]  = '{191113, 151686, 127552, 95556};
  int tbl_s [0:7]  = '{127552, 0, 127552, 95556, 75843, 0, 95556, 63776};
  int tbl_o [0:15] = '{127552, 151686, 191113, 0, 255102, 303370, 382226, 0,
                       454545, 0, 510204, 510204, 0, 764526, 764526, 764526};

  // Reference model: phase 0 idle, 1 playing, 2 gap.
  int m_phase, m_act, m_beat, m_gap, m_done, m_note;
  int m_pend [4];
  int m_prev [4];

  int tick_src;      // 0 caller drives, 1 periodic, 2 random
  int tick_period;
  int cyc;
  int done_cnt, loud, max_beat, last_act;
  int started [$];

  function automatic int len_of(int id);
    return (id == 1) ? 4 : (id == 2) ? 8 : 16;
  endfunction

  function automatic int tbl(int id, int b);
    int v;
    if (id == 1)      v = tbl_j[b];
    else if (id == 2) v = tbl_s[b];
    else              v = tbl_o[b];
    return (v == 0) ? SIL : v;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_act = 0; m_beat = 0; m_gap = 0; m_done = 0; m_note = SIL;
    for (int i = 0; i < 4; i++) begin m_pend[i] = 0; m_prev[i] = 0; end
  endtask

  task automatic model_step();
    int r [4];
    int hi, grant, old_phase, old_act;
    if (rst) begin model_reset(); return; end
    r = '{0, int'(req_jump), int'(req_score), int'(req_over)};
    m_note = (m_phase == 1 && !mute) ? tbl(m_act, m_beat) : SIL;
    hi = 0;
    for (int i = 1; i <= 3; i++) if (m_pend[i] != 0) hi = i;
    old_phase = m_phase; old_act = m_act; grant = 0; m_done = 0;
    if (m_phase == 0) begin
      if (hi != 0) begin grant = hi; m_phase = 1; m_act = hi; m_beat = 0; end
    end else if (m_phase == 1) begin
      if (hi > m_act) begin
        grant = hi; m_act = hi; m_beat = 0;
      end else if (beat_tick) begin
        if (m_beat == len_of(m_act) - 1) begin
          m_done = 1; m_act = 0; m_beat = 0; m_gap = GAP;
          m_phase = (GAP > 0) ? 2 : 0;
        end else begin
          m_beat++;
        end
      end
    end else if (beat_tick) begin
      m_gap--;
      if (m_gap == 0) m_phase = 0;
    end
    for (int i = 1; i <= 3; i++) begin
      if (grant == i) m_pend[i] = 0;
      else if (r[i] != 0 && m_prev[i] == 0 && !(old_phase == 1 && old_act == i)) m_pend[i] = 1;
      m_prev[i] = r[i];
    end
  endtask

  task automatic clear_track();
    done_cnt = 0; loud = 0; max_beat = 0; started.delete();
  endtask

  // One clock: pick the tick, advance model with the DUT, compare #1 later.
  task automatic step();
    if (tick_src == 1)      beat_tick = (cyc % tick_period == 0);
    else if (tick_src == 2) beat_tick = ($urandom_range(0, 3) == 0);
    @(posedge clk);
    model_step();
    #1;
    check("note_div", note_div, m_note);
    check("active_id", active_id, m_act);
    check("beat_idx", beat_idx, m_beat);
    check("busy", busy, m_phase != 0);
    check("done", done, m_done);
    if (done) done_cnt++;
    if (note_div != 22'(SIL)) loud++;
    if (int'(beat_idx) > max_beat) max_beat = beat_idx;
    if (active_id != 0 && int'(active_id) != last_act) started.push_back(active_id);
    last_act = active_id;
    cyc++;
  endtask

  task automatic wait_idle(string name);
    int n;
    bit pend;
    n = 0;
    repeat (3) step();
    pend = 1;
    while (pend && n < 2000) begin
      step(); n++;
      pend = (m_phase != 0) || (m_pend[1] != 0) || (m_pend[2] != 0) || (m_pend[3] != 0);
    end
    check(name, n < 2000, 1);
  endtask

  typedef struct {
    bit jump;
    bit tick;
    int act;
    int beat;
    bit busy;
    bit done;
    int note;
  } vec_t;
  vec_t vt [10];

  initial begin
    int n;
    // Jump effect, expectations after each clock edge.
    vt[0] = '{1, 0, 0, 0, 0, 0, SIL};
    vt[1] = '{0, 1, 1, 0, 1, 0, SIL};     // tick at grant ignored
    vt[2] = '{0, 1, 1, 1, 1, 0, 191113};
    vt[3] = '{0, 0, 1, 1, 1, 0, 151686};
    vt[4] = '{0, 1, 1, 2, 1, 0, 151686};
    vt[5] = '{0, 1, 1, 3, 1, 0, 127552};
    vt[6] = '{0, 1, 0, 0, 1, 1, 95556};   // done, into gap
    vt[7] = '{0, 0, 0, 0, 1, 0, SIL};
    vt[8] = '{0, 1, 0, 0, 1, 0, SIL};
    vt[9] = '{0, 1, 0, 0, 0, 0, SIL};     // second gap beat ends

    rst = 1; beat_tick = 0; req_jump = 0; req_score = 0; req_over = 0; mute = 0;
    tick_src = 0; tick_period = 4; cyc = 0; last_act = 0;
    model_reset(); clear_track();
    repeat (2) @(posedge clk);
    #1;
    check("rst_note_div", note_div, SIL);
    check("rst_active_id", active_id, 0);
    check("rst_beat_idx", beat_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 0;

    for (int i = 0; i < 10; i++) begin
      req_jump = vt[i].jump; beat_tick = vt[i].tick;
      step();
      $display("vec %0d: active=%0d beat=%0d busy=%0d done=%0d note=%0d", i, active_id, beat_idx, busy, done, note_div);
      check("tbl_active", active_id, vt[i].act);
      check("tbl_beat", beat_idx, vt[i].beat);
      check("tbl_busy", busy, vt[i].busy);
      check("tbl_done", done, vt[i].done);
      check("tbl_note", note_div, vt[i].note);
    end

    // Simultaneous jump + score: score first, then jump.
    tick_src = 1; tick_period = 4; clear_track();
    req_jump = 1; req_score = 1; step(); req_jump = 0; req_score = 0;
    wait_idle("tie_idle");
    $display("tie: dones=%0d starts=%0d", done_cnt, started.size());
    check("tie_dones", done_cnt, 2);
    check("tie_starts", started.size(), 2);
    if (started.size() == 2) begin
      check("tie_first", started[0], 2);
      check("tie_second", started[1], 1);
    end

    // Game over preempts score at beat 3.
    clear_track();
    req_score = 1; step(); req_score = 0;
    n = 0;
    while (!(active_id == 2 && beat_idx == 3) && n < 300) begin step(); n++; end
    check("pre_reach_b3", n < 300, 1);
    req_over = 1; step(); req_over = 0; step();
    $display("preempt: active=%0d beat=%0d dones=%0d", active_id, beat_idx, done_cnt);
    check("pre_active", active_id, 3);
    check("pre_beat", beat_idx, 0);
    check("pre_no_done", done_cnt, 0);
    wait_idle("pre_idle");
    check("pre_dones", done_cnt, 1);
    check("pre_starts", started.size(), 2);

    // Muted jump still sequences.
    mute = 1; clear_track();
    req_jump = 1; step(); req_jump = 0;
    wait_idle("mute_idle");
    mute = 0;
    $display("mute: loud=%0d dones=%0d maxbeat=%0d", loud, done_cnt, max_beat);
    check("mute_silent", loud, 0);
    check("mute_done", done_cnt, 1);
    check("mute_maxbeat", max_beat, 3);

    // Held request with a second edge while the jump plays.
    tick_period = 8; clear_track();
    for (int i = 0; i < 100; i++) begin
      req_jump = (i != 15);
      step();
    end
    req_jump = 0;
    wait_idle("held_idle");
    $display("held: starts=%0d dones=%0d", started.size(), done_cnt);
    check("held_starts", started.size(), 1);
    check("held_dones", done_cnt, 1);

    // Reset at beat 5 of game over, score held through reset.
    tick_period = 4;
    req_over = 1; step(); req_over = 0;
    n = 0;
    while (!(active_id == 3 && beat_idx == 5) && n < 300) begin step(); n++; end
    check("rst_reach_b5", n < 300, 1);
    clear_track();
    req_score = 1; rst = 1;
    #1;
    $display("midrst: active=%0d beat=%0d busy=%0d note=%0d", active_id, beat_idx, busy, note_div);
    check("midrst_active", active_id, 0);
    check("midrst_beat", beat_idx, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_note", note_div, SIL);
    model_reset();
    repeat (3) step();
    rst = 0;
    wait_idle("postrst_idle");
    req_score = 0;
    $display("postrst: starts=%0d dones=%0d", started.size(), done_cnt);
    check("postrst_starts", started.size(), 1);
    if (started.size() == 1) check("postrst_id", started[0], 2);
    check("postrst_dones", done_cnt, 1);

    // Randomized traffic against the model.
    tick_src = 2;
    for (int i = 0; i < 3000; i++) begin
      req_jump  = ($urandom_range(0, 15) == 0);
      req_score = ($urandom_range(0, 31) == 0);
      req_over  = ($urandom_range(0, 63) == 0);
      mute      = ($urandom_range(0, 7) == 0);
      step();
    end
    req_jump = 0; req_score = 0; req_over = 0; mute = 0;
    wait_idle("rand_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
